// File: rtl/riscv_dm_pkg.sv
// Shared debug-module definitions: DMI field widths, response codes and request op encoding.
package riscv_dm_pkg;

   localparam int unsigned DMI_ADDR_WIDTH = 7;
   localparam int unsigned DMI_DATA_WIDTH = 32;
   localparam int unsigned DMI_OP_WIDTH   = 2;

   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_SUCCESS = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED  = 2'd2;
   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_BUSY    = 2'd3;

   // Encoding 3 is reserved and deliberately has no enumerator.
   typedef enum logic [DMI_OP_WIDTH-1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2
   } dmi_req_op_t;

endpackage

// File: rtl/riscv_dmi_responder_if.sv
// DMI request/response channel plus the register-side access port of the responder.
interface riscv_dmi_responder_if;
   import riscv_dm_pkg::*;

   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [DMI_ADDR_WIDTH-1:0] req_addr_i;
   logic [DMI_DATA_WIDTH-1:0] req_data_i;
   logic [DMI_OP_WIDTH-1:0]   req_op_i;
   logic                      resp_valid_o;
   logic                      resp_ready_i;
   logic [DMI_DATA_WIDTH-1:0] resp_data_o;
   logic [DMI_OP_WIDTH-1:0]   resp_op_o;
   logic                      reg_req_o;
   logic                      reg_we_o;
   logic [DMI_ADDR_WIDTH-1:0] reg_addr_o;
   logic [DMI_DATA_WIDTH-1:0] reg_wdata_o;
   logic                      reg_gnt_i;
   logic                      reg_rvalid_i;
   logic [DMI_DATA_WIDTH-1:0] reg_rdata_i;
   logic                      reg_err_i;

   // Environment view: drives the DTM side and plays the register file.
   modport master (
      output req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
             reg_gnt_i, reg_rvalid_i, reg_rdata_i, reg_err_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_op_o,
             reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
             reg_gnt_i, reg_rvalid_i, reg_rdata_i, reg_err_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_op_o,
             reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o
   );

endinterface

// File: rtl/riscv_dmi_responder.sv
// Single-outstanding DMI responder: turns DTM requests into register-side accesses
// and returns a response, failing the access if the register side stalls too long.
module riscv_dmi_responder
   import riscv_dm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   riscv_dmi_responder_if.slave  dmi
);

   localparam int unsigned         CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]    TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_RESP
   } state_e;

   state_e                    state_q, state_d;
   logic                      rdy_q, rdy_d;
   logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DMI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DMI_OP_WIDTH-1:0]   op_q, op_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [DMI_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic [DMI_OP_WIDTH-1:0]   resp_op_q, resp_op_d;
   logic [CNT_W-1:0]          cnt_inc;
   logic                      tmo;
   logic                      accept;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      resp_data_d = resp_data_q;
      resp_op_d   = resp_op_q;
      // tmo marks the last cycle an access may still complete in
      cnt_inc     = cnt_q + CNT_W'(1);
      tmo         = (cnt_inc == TMO_VAL);
      accept      = dmi.req_valid_i && rdy_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d      = dmi.req_addr_i;
               wdata_d     = dmi.req_data_i;
               op_d        = dmi.req_op_i;
               cnt_d       = '0;
               resp_data_d = '0;
               if (dmi.req_op_i == DMI_READ || dmi.req_op_i == DMI_WRITE) begin
                  state_d = S_ACCESS;
               end else if (dmi.req_op_i == DMI_NOP) begin
                  resp_op_d = RD_OP_SUCCESS;
                  state_d   = S_RESP;
               end else begin
                  resp_op_d = RD_OP_FAILED;
                  state_d   = S_RESP;
               end
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_inc;
            if (tmo) begin
               resp_op_d   = RD_OP_FAILED;
               resp_data_d = '0;
               state_d     = S_RESP;
            end else if (dmi.reg_gnt_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (dmi.reg_rvalid_i) begin
               resp_op_d   = dmi.reg_err_i ? RD_OP_FAILED : RD_OP_SUCCESS;
               resp_data_d = (!dmi.reg_err_i && op_q == DMI_READ) ? dmi.reg_rdata_i : '0;
               state_d     = S_RESP;
            end else if (tmo) begin
               resp_op_d   = RD_OP_FAILED;
               resp_data_d = '0;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (dmi.resp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered ready stays low through reset and rises on the first edge after it.
      rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         rdy_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         resp_data_q <= '0;
         resp_op_q   <= '0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         resp_data_q <= resp_data_d;
         resp_op_q   <= resp_op_d;
      end
   end

   assign dmi.req_ready_o  = rdy_q;
   assign dmi.resp_valid_o = (state_q == S_RESP);
   assign dmi.resp_data_o  = resp_data_q;
   assign dmi.resp_op_o    = resp_op_q;
   assign dmi.reg_req_o    = (state_q == S_ACCESS) && !tmo;
   assign dmi.reg_we_o     = (op_q == DMI_WRITE);
   assign dmi.reg_addr_o   = addr_q;
   assign dmi.reg_wdata_o  = wdata_q;

endmodule
